snake_cmd_seq: RTL

Parametrised successor to the snake game core's draw-command generator. It produces a periodic game tick and latches joystick direction, with a reversal guard. On each tick it snapshots NUM_OBJ object positions and emits one point draw-command per enabled object over a valid/ready handshake to the VGA command consumer. After reset it emits a full-screen clear rectangle first.

---
 rtl/snake_pkg.sv | 29 ++
 rtl/snake_tick_gen.sv | 45 ++++
 rtl/snake_cmd_seq.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
//   Shared definitions for the snake game command path: joystick direction
//   encoding, draw-command opcodes, the draw-command width helper and the
//   command sequencer state encoding.
// -----------------------------------------------------------------------------
package snake_pkg;

    // Opposite directions are bitwise complements of each other.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam logic [3:0] CMD_OP_POINT = 4'h0;
    localparam logic [3:0] CMD_OP_RECT  = 4'h1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_EMIT = 2'd2
    } seq_state_e;

    // opcode + two (x,y) pairs + colour
    function automatic int cmd_width(input int h_w, input int v_w, input int c_w);
        return 4 + 2 * (h_w + v_w) + c_w;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// -----------------------------------------------------------------------------
// snake_tick_gen
//   Free-running game tick divider. Counts clocks while enb is high and emits
//   a one-cycle tick on the last count of each period, wrapping to zero.
//   Shared by the command sequencer and the prey/body blocks.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   enb    in   count enable; counter holds and tick stays low when 0
//   tick   out  one-cycle pulse every TICK_PERIOD enabled clocks
// -----------------------------------------------------------------------------
module snake_tick_gen #(
    parameter int TICK_CNT_WIDTH = 25,
    parameter int TICK_PERIOD    = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enb,
    output logic tick
);

    localparam logic [TICK_CNT_WIDTH-1:0] CNT_LAST = TICK_CNT_WIDTH'(TICK_PERIOD - 1);

    logic [TICK_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (enb) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + TICK_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/snake_cmd_seq.sv
// -----------------------------------------------------------------------------
// snake_cmd_seq
//   Draw-command generator for the snake game core. Produces the game tick,
//   latches the joystick direction (ignoring reversals), and on every tick
//   snapshots NUM_OBJ object positions and emits one point command per enabled
//   object over a valid/ready handshake. After reset a full-screen clear rect
//   is emitted first.
//
//   Build option: define SNAKE_CMD_BORDER_EN to also emit four border rects
//   (top, bottom, left, right) after the clear.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enb              game enable: freezes tick counter and direction when low
//   up/down/left/right  joystick buttons (priority up > down > left > right)
//   obj_x/obj_y/obj_color/obj_en  per-object position, colour, draw enable
//   tick             one-cycle game tick
//   dir              latched direction
//   cmd, cmd_vld, cmd_rdy  draw command stream (registered valid)
//   busy             sequencer not idle
//   overrun          sticky: a tick arrived while the sequencer was busy
// -----------------------------------------------------------------------------
module snake_cmd_seq
    import snake_pkg::*;
#(
    parameter int                        H_LOGIC_WIDTH  = 5,
    parameter int                        V_LOGIC_WIDTH  = 5,
    parameter int                        H_LOGIC_MAX    = 31,
    parameter int                        V_LOGIC_MAX    = 23,
    parameter int                        COLOR_ID_WIDTH = 8,
    parameter int                        NUM_OBJ        = 3,
    parameter int                        TICK_CNT_WIDTH = 25,
    parameter int                        TICK_PERIOD    = 12500000,
    parameter logic [COLOR_ID_WIDTH-1:0] BG_COLOR       = 8'hff,
    parameter logic [COLOR_ID_WIDTH-1:0] BORDER_COLOR   = 8'h00
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enb,
    input  logic                                  up,
    input  logic                                  down,
    input  logic                                  left,
    input  logic                                  right,
    input  logic [NUM_OBJ*H_LOGIC_WIDTH-1:0]      obj_x,
    input  logic [NUM_OBJ*V_LOGIC_WIDTH-1:0]      obj_y,
    input  logic [NUM_OBJ*COLOR_ID_WIDTH-1:0]     obj_color,
    input  logic [NUM_OBJ-1:0]                    obj_en,
    output logic                                  tick,
    output logic [1:0]                            dir,
    output logic [cmd_width(H_LOGIC_WIDTH, V_LOGIC_WIDTH, COLOR_ID_WIDTH)-1:0] cmd,
    output logic                                  cmd_vld,
    input  logic                                  cmd_rdy,
    output logic                                  busy,
    output logic                                  overrun
);

    localparam int CMD_W = cmd_width(H_LOGIC_WIDTH, V_LOGIC_WIDTH, COLOR_ID_WIDTH);
    localparam int IDX_W = (NUM_OBJ < 2) ? 1 : $clog2(NUM_OBJ + 1);

    localparam logic [IDX_W-1:0]         IDX_END = IDX_W'(NUM_OBJ);
    localparam logic [H_LOGIC_WIDTH-1:0] HMAX    = H_LOGIC_WIDTH'(H_LOGIC_MAX);
    localparam logic [V_LOGIC_WIDTH-1:0] VMAX    = V_LOGIC_WIDTH'(V_LOGIC_MAX);
    localparam logic [H_LOGIC_WIDTH-1:0] H0      = '0;
    localparam logic [V_LOGIC_WIDTH-1:0] V0      = '0;

    // Index of the last INIT rect: clear only, or clear + four borders.
`ifdef SNAKE_CMD_BORDER_EN
    localparam logic [2:0] INIT_LAST = 3'd4;
`else
    localparam logic [2:0] INIT_LAST = 3'd0;
`endif

    // ---------------------------------------------------------------- helpers
    function automatic logic [CMD_W-1:0] point_cmd(
        input logic [H_LOGIC_WIDTH-1:0]  x,
        input logic [V_LOGIC_WIDTH-1:0]  y,
        input logic [COLOR_ID_WIDTH-1:0] c
    );
        return {CMD_OP_POINT, x, y, c, {(H_LOGIC_WIDTH + V_LOGIC_WIDTH){1'b0}}};
    endfunction

    function automatic logic [CMD_W-1:0] rect_cmd(
        input logic [H_LOGIC_WIDTH-1:0]  x0,
        input logic [V_LOGIC_WIDTH-1:0]  y0,
        input logic [H_LOGIC_WIDTH-1:0]  x1,
        input logic [V_LOGIC_WIDTH-1:0]  y1,
        input logic [COLOR_ID_WIDTH-1:0] c
    );
        return {CMD_OP_RECT, x0, y0, x1, y1, c};
    endfunction

    // INIT step 0 is the clear; steps 1..4 are the borders.
    function automatic logic [CMD_W-1:0] init_cmd(input logic [2:0] step);
        case (step)
            3'd1:    return rect_cmd(H0,   V0,   HMAX, V0,   BORDER_COLOR);
            3'd2:    return rect_cmd(H0,   VMAX, HMAX, VMAX, BORDER_COLOR);
            3'd3:    return rect_cmd(H0,   V0,   H0,   VMAX, BORDER_COLOR);
            3'd4:    return rect_cmd(HMAX, V0,   HMAX, VMAX, BORDER_COLOR);
            default: return rect_cmd(H0,   V0,   HMAX, VMAX, BG_COLOR);
        endcase
    endfunction

    // ---------------------------------------------------------------- tick
    snake_tick_gen #(
        .TICK_CNT_WIDTH (TICK_CNT_WIDTH),
        .TICK_PERIOD    (TICK_PERIOD)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .enb   (enb),
        .tick  (tick)
    );

    // ---------------------------------------------------------------- direction
    logic [1:0] dir_q, dir_d;
    logic [1:0] dir_cand;
    logic       dir_cand_vld;

    always_comb begin
        dir_cand     = dir_q;
        dir_cand_vld = 1'b1;
        if      (up)    dir_cand = DIR_UP;
        else if (down)  dir_cand = DIR_DOWN;
        else if (left)  dir_cand = DIR_LEFT;
        else if (right) dir_cand = DIR_RIGHT;
        else            dir_cand_vld = 1'b0;

        dir_d = dir_q;
        // A reversal request is dropped, not replaced by a lower-priority button.
        if (enb && dir_cand_vld && (dir_cand != ~dir_q))
            dir_d = dir_cand;
    end

    // ---------------------------------------------------------------- sequencer
    seq_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       init_q, init_d;
    logic             vld_q, vld_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             overrun_q, overrun_d;

    logic [NUM_OBJ-1:0][H_LOGIC_WIDTH-1:0]  snap_x_q, snap_x_d;
    logic [NUM_OBJ-1:0][V_LOGIC_WIDTH-1:0]  snap_y_q, snap_y_d;
    logic [NUM_OBJ-1:0][COLOR_ID_WIDTH-1:0] snap_c_q, snap_c_d;
    logic [NUM_OBJ-1:0]                     snap_en_q, snap_en_d;

    // Current command slot is finished: either nothing presented or accepted.
    logic             slot_done;
    logic [IDX_W-1:0] idx_nxt;
    logic             idx_last;

    // Snapshot entry for idx_nxt; loop compare keeps index widths exact.
    logic [H_LOGIC_WIDTH-1:0]  sel_x;
    logic [V_LOGIC_WIDTH-1:0]  sel_y;
    logic [COLOR_ID_WIDTH-1:0] sel_c;
    logic                      sel_en;

    assign slot_done = !vld_q || cmd_rdy;
    assign idx_nxt   = idx_q + IDX_W'(1);
    assign idx_last  = (idx_nxt == IDX_END);

    always_comb begin
        sel_x  = '0;
        sel_y  = '0;
        sel_c  = '0;
        sel_en = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                sel_x  = snap_x_q[i];
                sel_y  = snap_y_q[i];
                sel_c  = snap_c_q[i];
                sel_en = snap_en_q[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            idx_q     <= '0;
            init_q    <= '0;
            vld_q     <= 1'b0;
            cmd_q     <= '0;
            overrun_q <= 1'b0;
            dir_q     <= DIR_RIGHT;
            snap_x_q  <= '0;
            snap_y_q  <= '0;
            snap_c_q  <= '0;
            snap_en_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            init_q    <= init_d;
            vld_q     <= vld_d;
            cmd_q     <= cmd_d;
            overrun_q <= overrun_d;
            dir_q     <= dir_d;
            snap_x_q  <= snap_x_d;
            snap_y_q  <= snap_y_d;
            snap_c_q  <= snap_c_d;
            snap_en_q <= snap_en_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        init_d  = init_q;
        case (state_q)
            ST_INIT: begin
                if (vld_q && cmd_rdy) begin
                    if (init_q == INIT_LAST) state_d = ST_IDLE;
                    else                     init_d  = init_q + 3'd1;
                end
            end
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_EMIT;
                    idx_d   = '0;
                end
            end
            ST_EMIT: begin
                if (slot_done) begin
                    if (idx_last) state_d = ST_IDLE;
                    else          idx_d   = idx_nxt;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Output / datapath next values. cmd and cmd_vld are registered, so the
    // command for the next slot is loaded one cycle ahead of presentation.
    always_comb begin
        vld_d     = vld_q;
        cmd_d     = cmd_q;
        snap_x_d  = snap_x_q;
        snap_y_d  = snap_y_q;
        snap_c_d  = snap_c_q;
        snap_en_d = snap_en_q;
        overrun_d = overrun_q | (tick && (state_q != ST_IDLE));
        case (state_q)
            ST_INIT: begin
                if (!vld_q) begin
                    vld_d = 1'b1;
                    cmd_d = init_cmd(init_q);
                end else if (cmd_rdy) begin
                    if (init_q == INIT_LAST) begin
                        vld_d = 1'b0;
                    end else begin
                        cmd_d = init_cmd(init_q + 3'd1);
                    end
                end
            end
            ST_IDLE: begin
                if (tick) begin
                    snap_x_d  = obj_x;
                    snap_y_d  = obj_y;
                    snap_c_d  = obj_color;
                    snap_en_d = obj_en;
                    // Object 0 goes straight from the live inputs so its
                    // command is valid the cycle after the tick.
                    vld_d = obj_en[0];
                    cmd_d = point_cmd(obj_x[H_LOGIC_WIDTH-1:0],
                                      obj_y[V_LOGIC_WIDTH-1:0],
                                      obj_color[COLOR_ID_WIDTH-1:0]);
                end
            end
            ST_EMIT: begin
                if (slot_done) begin
                    if (idx_last) begin
                        vld_d = 1'b0;
                    end else begin
                        vld_d = sel_en;
                        cmd_d = point_cmd(sel_x, sel_y, sel_c);
                    end
                end
            end
            default: vld_d = 1'b0;
        endcase
    end

    assign dir     = dir_q;
    assign cmd     = cmd_q;
    assign cmd_vld = vld_q;
    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;

endmodule
